uart3_rx_fifo: RTL and testbench
================================

// Module: uart3_rx_fifo
// PURPOSE
//  Next-generation UART receiver for the control path ahead of uart_decoder3.
//  Baud rate, word width, oversampling and an RX FIFO are all parametrised.
//  Frames are validated for start, stop and (optionally) parity errors.
//  Valid words are buffered in a show-ahead FIFO; the decoder drains it with byte_rdy/uld_rx_data.
// PARAMETERS
//  DATA_BITS   8           data bits per frame (5..9), sent LSB first
//  BAUD        9600        line baud rate
//  CLK_FREQ    40000000    clk frequency, Hz
//  OVERSAMPLE  16          sample ticks per bit (even, >=8)
//  FIFO_DEPTH  4           RX FIFO words (power of 2, >=2)
//  PARITY_ODD  0           0 = even parity, 1 = odd (used only with UART3_RX_PARITY_EN)
// PORTS
//  clk          in   1                          system clock
//  reset        in   1                          asynchronous, active-high reset
//  rx_enable    in   1                          1 = receiver runs; 0 = aborts frame, holds IDLE
//  rx_in        in   1                          serial line, idle high, asynchronous
//  uld_rx_data  in   1                          pop head word (1-clk pulse)
//  rx_data      out  DATA_BITS                  FIFO head word (show-ahead)
//  byte_rdy     out  1                          FIFO not empty
//  fifo_count   out  $clog2(FIFO_DEPTH)+1       words held
//  frame_err    out  1                          1-clk pulse: stop bit sampled 0
//  parity_err   out  1                          1-clk pulse: parity mismatch
//  overrun_err  out  1                          1-clk pulse: word dropped, FIFO full
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM in IDLE, divider cleared, synchroniser set to 1.
//  - rx_in passes a 2-FF synchroniser. Tick divider = round(CLK_FREQ/(BAUD*OVERSAMPLE)).
//    The divider is free-running and re-zeroed on each start edge.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: a synchronised falling edge enters START.
//  - START: samples at OVERSAMPLE/2 ticks. Low continues to DATA; high is a glitch, back to IDLE with no output.
//  - DATA: DATA_BITS samples, each OVERSAMPLE ticks apart, shifted in LSB first.
//  - STOP: samples at mid-bit.
//    - Stop=1 and no error: push the word on that clock edge; byte_rdy/fifo_count update the next clk.
//    - Stop=0: frame_err pulses and the word is dropped.
//    - Either way, return to IDLE without waiting for the line to rise. IDLE still needs a fresh falling edge.
//  - Push when full (and no pop that cycle): word dropped, overrun_err pulses, contents unchanged.
//  - Push and pop in the same cycle: both succeed, including at full, where count is unchanged.
//  - uld_rx_data while empty: ignored. rx_data is undefined-but-stable when empty; it holds its last value.
//  - rx_enable=0: FSM forced to IDLE within 1 clk and any partial frame is discarded.
//    FIFO contents and the pop path are unaffected.
//  - reset mid-frame: immediate return to the reset state; FIFO contents are lost.
//  - Error pulses are mutually exclusive per frame. Priority: frame_err > parity_err > overrun_err.
// CONFIGURATION
//  - UART3_RX_PARITY_EN defined:
//    - A PARITY state follows DATA and samples one parity bit.
//    - Mismatch against PARITY_ODD pulses parity_err and the word is dropped.
//  - UART3_RX_PARITY_EN undefined:
//    - No PARITY state; the frame is start + DATA_BITS + stop.
//    - parity_err is tied 0 and PARITY_ODD is ignored.
// TESTING  (clk 40 MHz, BAUD 9600, bit period 104166.667 ns, defaults unless noted)
//  1. Frame: start, data bits 0,1,0,1,0,1,0,0, stop.
//     -> byte_rdy=1, rx_data=8'h2A, fifo_count=1, no errors. One uld_rx_data pulse -> byte_rdy=0, count=0.
//  2. Five frames 8'h01..8'h05 back-to-back, no unload.
//     -> count=4, one overrun_err pulse on the 5th frame. Four pops return 01,02,03,04.
//  3. Frame 8'h2A with the stop bit driven 0.
//     -> one frame_err pulse, count stays 0. A following good 8'h55 frame is received correctly.
//  4. rx_in low for 2 us, then high.
//     -> no start accepted, no output, no error pulses.
//  5. With UART3_RX_PARITY_EN, PARITY_ODD=0, byte 8'h2A:
//     -> parity bit 1 accepted (count=1); parity bit 0 gives a parity_err pulse and count stays 1.
//  6. reset pulsed during data bit 4.
//     -> all outputs 0 and FIFO empty. Next frame 8'hA5 is received correctly.
//     rx_enable=0 mid-frame gives the same discard, with the FIFO kept.

Source files
------------

// File: rtl/uart3_rx_fifo.sv
// rtl/uart3_rx_fifo.sv - oversampling UART receiver with show-ahead RX FIFO
// Optional parity stage enabled by defining UART3_RX_PARITY_EN.
module uart3_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD       = 9600,
    parameter int CLK_FREQ   = 40000000,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_enable,
    input  logic                          rx_in,
    input  logic                          uld_rx_data,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          byte_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err
);
    localparam int DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_next;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [DW-1:0]        div_cnt;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 fall, tick, half_pt, bit_end;
    logic                 push, frame_c, pop_ok, push_ok, full;
`ifdef UART3_RX_PARITY_EN
    logic                 par_bad, parity_c;
`endif

    assign fall    = rx_prev & ~rx_sync;
    assign tick    = (div_cnt == DW'(DIV - 1));
    assign half_pt = tick && (tick_cnt == TW'(OVERSAMPLE / 2 - 1));
    assign bit_end = tick && (tick_cnt == TW'(OVERSAMPLE - 1));

    always_comb begin
        state_next = state;
        push       = 1'b0;
        frame_c    = 1'b0;
`ifdef UART3_RX_PARITY_EN
        parity_c   = 1'b0;
`endif
        if (!rx_enable) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (fall) state_next = S_START;
                S_START: if (half_pt) state_next = rx_sync ? S_IDLE : S_DATA;
                S_DATA: begin
                    if (bit_end && bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART3_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
                S_PARITY: if (bit_end) state_next = S_STOP;
                S_STOP: begin
                    if (bit_end) begin
                        state_next = S_IDLE;
                        if (!rx_sync) frame_c = 1'b1;
`ifdef UART3_RX_PARITY_EN
                        else if (par_bad) parity_c = 1'b1;
`endif
                        else push = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            div_cnt     <= '0;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state   <= state_next;
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            // Divider restarts on the start edge so sample points sit mid-bit
            if ((state == S_IDLE && fall) || tick) div_cnt <= '0;
            else                                   div_cnt <= div_cnt + DW'(1);
            if (state_next != state || bit_end) tick_cnt <= '0;
            else if (tick)                      tick_cnt <= tick_cnt + TW'(1);
            if (state != S_DATA) bit_cnt <= '0;
            else if (bit_end)    bit_cnt <= bit_cnt + BW'(1);
            if (state == S_DATA && bit_end) shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
            frame_err   <= frame_c;
            overrun_err <= push && !push_ok;
        end
    end

`ifdef UART3_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == S_PARITY && bit_end)
                par_bad <= rx_sync != ((^shreg) ^ PARITY_ODD[0]);
            parity_err <= parity_c;
        end
    end
`else
    // PARITY_ODD has no effect without the parity stage
    assign parity_err = 1'b0 & PARITY_ODD[0];
`endif

    assign full       = (count == CW'(FIFO_DEPTH));
    assign pop_ok     = uld_rx_data && (count != '0);
    assign push_ok    = push && (!full || pop_ok);
    assign byte_rdy   = (count != '0);
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    // rx_data is a register so it keeps its last value once the FIFO drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rx_data <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
            if (pop_ok && count == CW'(1) && push_ok) rx_data <= shreg;
            else if (pop_ok && count > CW'(1))        rx_data <= mem[rd_ptr + PW'(1)];
            else if (!pop_ok && count == '0 && push_ok) rx_data <= shreg;
        end
    end
endmodule

// File: tb/tb_uart3_rx_fifo.sv
// tb/tb_uart3_rx_fifo.sv - directed self-checking bench for uart3_rx_fifo
`timescale 1ns/1ps
module tb_uart3_rx_fifo;
    localparam int  BIT_NS = 8000;   // 125000 baud: 40 MHz / (125000*16) = 20 exactly

    logic       clk = 1'b0;
    logic       reset, rx_enable, rx_in, uld_rx_data;
    logic [7:0] rx_data;
    logic       byte_rdy;
    logic [2:0] fifo_count;
    logic       frame_err, parity_err, overrun_err;

    int tests = 0;
    int fails = 0;
    int n_frame = 0, n_par = 0, n_ovr = 0;
    int f0, p0, o0;

    uart3_rx_fifo #(.DATA_BITS(8), .BAUD(125000), .CLK_FREQ(40000000),
                    .OVERSAMPLE(16), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .rx_enable(rx_enable), .rx_in(rx_in),
        .uld_rx_data(uld_rx_data), .rx_data(rx_data), .byte_rdy(byte_rdy),
        .fifo_count(fifo_count), .frame_err(frame_err), .parity_err(parity_err),
        .overrun_err(overrun_err));

    always #12.5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err)   n_frame++;
        if (parity_err)  n_par++;
        if (overrun_err) n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        f0 = n_frame; p0 = n_par; o0 = n_ovr;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        rx_in = 1'b0; #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i]; #(BIT_NS);
        end
`ifdef UART3_RX_PARITY_EN
        rx_in = par; #(BIT_NS);
`else
        if (par === 1'bx) rx_in = 1'b1;
`endif
        rx_in = stop; #(BIT_NS);
        rx_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic good(input logic [7:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    // Drive start plus bits 0..3, then stop halfway through data bit 4
    task automatic partial(input logic [7:0] d);
        rx_in = 1'b0; #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx_in = d[i]; #(BIT_NS);
        end
        rx_in = d[4]; #(BIT_NS / 2);
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check(tag, rx_data, exp);
        uld_rx_data = 1'b1;
        @(negedge clk);
        uld_rx_data = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_enable = 1'b1; rx_in = 1'b1; uld_rx_data = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rx_data", rx_data, 0);
        check("rst_byte_rdy", byte_rdy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_errs", {frame_err, parity_err, overrun_err}, 0);
        repeat (4) @(negedge clk);

        // single frame 0x2A, then pop
        snap();
        good(8'h2A);
        check("t1_byte_rdy", byte_rdy, 1);
        check("t1_count", fifo_count, 1);
        check("t1_errs", (n_frame - f0) + (n_par - p0) + (n_ovr - o0), 0);
        pop("t1_data", 8'h2A);
        check("t1_empty", byte_rdy, 0);
        check("t1_count0", fifo_count, 0);
        uld_rx_data = 1'b1;
        @(negedge clk);
        uld_rx_data = 1'b0;
        check("t1_pop_empty", fifo_count, 0);

        // five frames into a 4-deep FIFO
        snap();
        for (int i = 1; i <= 5; i++) good(8'(i));
        check("t2_count", fifo_count, 4);
        check("t2_overrun", n_ovr - o0, 1);
        check("t2_no_frame", n_frame - f0, 0);
        pop("t2_pop1", 8'h01);
        pop("t2_pop2", 8'h02);
        pop("t2_pop3", 8'h03);
        pop("t2_pop4", 8'h04);
        check("t2_empty", fifo_count, 0);

        // stop bit low, then a good frame
        snap();
        send_frame(8'h2A, 1'b1, 1'b0);
        check("t3_frame_err", n_frame - f0, 1);
        check("t3_count", fifo_count, 0);
        check("t3_no_overrun", n_ovr - o0, 0);
        #(BIT_NS);
        good(8'h55);
        check("t3_count_good", fifo_count, 1);
        pop("t3_data", 8'h55);

        // 2 us glitch
        snap();
        rx_in = 1'b0; #2000; rx_in = 1'b1;
        #(3 * BIT_NS);
        @(negedge clk);
        check("t4_count", fifo_count, 0);
        check("t4_byte_rdy", byte_rdy, 0);
        check("t4_errs", (n_frame - f0) + (n_par - p0) + (n_ovr - o0), 0);

`ifdef UART3_RX_PARITY_EN
        snap();
        send_frame(8'h2A, 1'b1, 1'b1);
        check("t5_par_ok", fifo_count, 1);
        send_frame(8'h2A, 1'b0, 1'b1);
        check("t5_par_err", n_par - p0, 1);
        check("t5_count", fifo_count, 1);
        pop("t5_data", 8'h2A);
`else
        check("t5_parity_tied", n_par, 0);
`endif

        // reset during data bit 4 loses FIFO contents
        good(8'h11);
        check("t6_preload", fifo_count, 1);
        partial(8'hF0);
        reset = 1'b1; rx_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_count", fifo_count, 0);
        check("t6_byte_rdy", byte_rdy, 0);
        check("t6_rx_data", rx_data, 0);
        #(2 * BIT_NS);
        good(8'hA5);
        check("t6_count_a5", fifo_count, 1);
        pop("t6_data", 8'hA5);

        // rx_enable drop mid-frame keeps the FIFO
        snap();
        good(8'h3C);
        partial(8'hF0);
        rx_enable = 1'b0; rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rx_enable = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        check("t7_count", fifo_count, 1);
        check("t7_head", rx_data, 8'h3C);
        good(8'h5A);
        check("t7_count2", fifo_count, 2);
        check("t7_errs", (n_frame - f0) + (n_par - p0) + (n_ovr - o0), 0);
        pop("t7_pop1", 8'h3C);
        pop("t7_pop2", 8'h5A);
        check("t7_empty", fifo_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
